// File: rtl/pixie_vram_arbiter_if.sv
// Bus bundle between the Pixie video fetcher, the CPU and the display RAM.
// The arbiter takes the slave view; requesters and the RAM sit on the master view.
interface pixie_vram_arbiter_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_data;
    logic              vid_oob;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_ack, vid_data, vid_oob, cpu_ack, cpu_rdata,
               ram_en, ram_we, ram_addr, ram_wdata, busy
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_ack, vid_data, vid_oob, cpu_ack, cpu_rdata,
               ram_en, ram_we, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/pixie_vram_arbiter.sv
// Round-robin arbiter/sequencer giving the Pixie video fetcher and the CPU
// shared access to one single-port synchronous display RAM.
module pixie_vram_arbiter #(
    parameter logic [15:0] VRAM_BASE = 16'h0900,
    parameter logic [15:0] VRAM_MASK = 16'h00FF
) (
    input  logic                  clk,
    input  logic                  reset,
    pixie_vram_arbiter_if.slave   bus
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

    state_t            state,       state_nxt;
    logic              grant_vid,   grant_vid_nxt;
    logic              lat_we,      lat_we_nxt;
    logic              last_vid,    last_vid_nxt;
    logic              vid_ack_q,   vid_ack_nxt;
    logic [DATA_W-1:0] vid_data_q,  vid_data_nxt;
    logic              vid_oob_q,   vid_oob_nxt;
    logic              cpu_ack_q,   cpu_ack_nxt;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_nxt;
    logic              ram_en_q,    ram_en_nxt;
    logic              ram_we_q,    ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_nxt;
    logic              busy_q,      busy_nxt;

    // On a tie, video wins unless it had the previous grant.
    logic pick_vid_c;
    assign pick_vid_c = bus.vid_req && (!bus.cpu_req || !last_vid);

    always_comb begin
        state_nxt     = state;
        grant_vid_nxt = grant_vid;
        lat_we_nxt    = lat_we;
        last_vid_nxt  = last_vid;
        vid_ack_nxt   = 1'b0;
        vid_data_nxt  = vid_data_q;
        vid_oob_nxt   = vid_oob_q;
        cpu_ack_nxt   = 1'b0;
        cpu_rdata_nxt = cpu_rdata_q;
        ram_en_nxt    = 1'b0;
        ram_we_nxt    = 1'b0;
        ram_addr_nxt  = ram_addr_q;
        ram_wdata_nxt = ram_wdata_q;

        case (state)
            IDLE: begin
                if (pick_vid_c) begin
                    grant_vid_nxt = 1'b1;
                    lat_we_nxt    = 1'b0;
                    ram_en_nxt    = 1'b1;
                    // Out-of-window fetches wrap into the window and flag it.
                    ram_addr_nxt  = VRAM_BASE | (bus.vid_addr & VRAM_MASK);
                    if ((bus.vid_addr & ~VRAM_MASK) != (VRAM_BASE & ~VRAM_MASK))
                        vid_oob_nxt = 1'b1;
                    state_nxt     = ACCESS;
                end else if (bus.cpu_req) begin
                    grant_vid_nxt = 1'b0;
                    lat_we_nxt    = bus.cpu_we;
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = bus.cpu_we;
                    ram_addr_nxt  = bus.cpu_addr;
                    if (bus.cpu_we)
                        ram_wdata_nxt = bus.cpu_wdata;
                    state_nxt     = ACCESS;
                end
            end
            ACCESS: begin
                // Only the CPU ever writes, so a write ack is always a CPU ack.
                if (lat_we) begin
                    cpu_ack_nxt = 1'b1;
                    state_nxt   = ACK;
                end else begin
                    state_nxt   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (grant_vid) begin
                    vid_data_nxt  = bus.ram_rdata;
                    vid_ack_nxt   = 1'b1;
                end else begin
                    cpu_rdata_nxt = bus.ram_rdata;
                    cpu_ack_nxt   = 1'b1;
                end
                state_nxt = ACK;
            end
            ACK: begin
                last_vid_nxt = grant_vid;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant_vid   <= 1'b0;
            lat_we      <= 1'b0;
            last_vid    <= 1'b0;
            vid_ack_q   <= 1'b0;
            vid_data_q  <= '0;
            vid_oob_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= VRAM_BASE;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant_vid   <= grant_vid_nxt;
            lat_we      <= lat_we_nxt;
            last_vid    <= last_vid_nxt;
            vid_ack_q   <= vid_ack_nxt;
            vid_data_q  <= vid_data_nxt;
            vid_oob_q   <= vid_oob_nxt;
            cpu_ack_q   <= cpu_ack_nxt;
            cpu_rdata_q <= cpu_rdata_nxt;
            ram_en_q    <= ram_en_nxt;
            ram_we_q    <= ram_we_nxt;
            ram_addr_q  <= ram_addr_nxt;
            ram_wdata_q <= ram_wdata_nxt;
            busy_q      <= busy_nxt;
        end
    end

    assign bus.vid_ack   = vid_ack_q;
    assign bus.vid_data  = vid_data_q;
    assign bus.vid_oob   = vid_oob_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pixie_vram_arbiter.sv
// Directed bench for pixie_vram_arbiter with a behavioural synchronous RAM
// preloaded so that address 0x0900+i holds byte i.
module tb_pixie_vram_arbiter;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   we_cycles;
    int   we_without_en;
    int   both_acks;
    logic [7:0] mem [256];

    pixie_vram_arbiter_if bus ();

    pixie_vram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM: read data appears one cycle after ram_en.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
            else            bus.ram_rdata <= mem[bus.ram_addr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (bus.ram_we)                 we_cycles++;
        if (bus.ram_we && !bus.ram_en)  we_without_en++;
        if (bus.vid_ack && bus.cpu_ack) both_acks++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++; if (bus.vid_ack !== 1'b0) begin miscompares++; $display("FAIL reset_vid_ack: got %b want 0", bus.vid_ack); end
        vectors++; if (bus.cpu_ack !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_ack: got %b want 0", bus.cpu_ack); end
        vectors++; if (bus.ram_en !== 1'b0) begin miscompares++; $display("FAIL reset_ram_en: got %b want 0", bus.ram_en); end
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
        vectors++; if (bus.ram_addr !== 16'h0900) begin miscompares++; $display("FAIL reset_ram_addr: got %h want 0900", bus.ram_addr); end
        vectors++; if (bus.ram_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_ram_wdata: got %h want 00", bus.ram_wdata); end
        vectors++; if (bus.vid_data !== 8'h00) begin miscompares++; $display("FAIL reset_vid_data: got %h want 00", bus.vid_data); end
        vectors++; if (bus.cpu_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_cpu_rdata: got %h want 00", bus.cpu_rdata); end
        vectors++; if (bus.vid_oob !== 1'b0) begin miscompares++; $display("FAIL reset_vid_oob: got %b want 0", bus.vid_oob); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_video_read();
        int we0;
        we0 = we_cycles;
        bus.vid_addr = 16'h0905;
        bus.vid_req  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            vectors++;
            if (bus.vid_ack !== ((c % 4) == 2)) begin
                miscompares++; $display("FAIL vid_read_ack c%0d: got %b want %b", c, bus.vid_ack, (c % 4) == 2);
            end
            vectors++;
            if (bus.ram_en !== ((c % 4) == 0)) begin
                miscompares++; $display("FAIL vid_read_ram_en c%0d: got %b want %b", c, bus.ram_en, (c % 4) == 0);
            end
            if ((c % 4) == 0) begin
                vectors++;
                if (bus.ram_addr !== 16'h0905) begin miscompares++; $display("FAIL vid_read_addr c%0d: got %h want 0905", c, bus.ram_addr); end
            end
            if ((c % 4) == 2) begin
                vectors++;
                if (bus.vid_data !== 8'h05) begin miscompares++; $display("FAIL vid_read_data c%0d: got %h want 05", c, bus.vid_data); end
            end
        end
        bus.vid_req = 1'b0;
        tick();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL vid_read_idle_busy: got %b want 0", bus.busy); end
        vectors++; if (we_cycles - we0 !== 0) begin miscompares++; $display("FAIL vid_read_no_we: got %0d want 0", we_cycles - we0); end
        vectors++; if (bus.vid_oob !== 1'b0) begin miscompares++; $display("FAIL vid_read_oob: got %b want 0", bus.vid_oob); end
    endtask

    task automatic test_cpu_write_read();
        int we0;
        we0 = we_cycles;
        bus.cpu_addr  = 16'h09F0;
        bus.cpu_wdata = 8'hA5;
        bus.cpu_we    = 1'b1;
        bus.cpu_req   = 1'b1;
        tick();
        vectors++; if (bus.ram_we !== 1'b1 || bus.ram_en !== 1'b1) begin miscompares++; $display("FAIL cpu_wr_en_we: got en=%b we=%b want 1 1", bus.ram_en, bus.ram_we); end
        vectors++; if (bus.ram_addr !== 16'h09F0 || bus.ram_wdata !== 8'hA5) begin miscompares++; $display("FAIL cpu_wr_addr_data: got %h/%h want 09f0/a5", bus.ram_addr, bus.ram_wdata); end
        vectors++; if (bus.cpu_ack !== 1'b0) begin miscompares++; $display("FAIL cpu_wr_ack_e0: got %b want 0", bus.cpu_ack); end
        tick();
        vectors++; if (bus.cpu_ack !== 1'b1) begin miscompares++; $display("FAIL cpu_wr_ack_e1: got %b want 1", bus.cpu_ack); end
        vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL cpu_wr_we_drop: got %b want 0", bus.ram_we); end
        bus.cpu_req = 1'b0;
        tick();
        vectors++; if (bus.cpu_ack !== 1'b0) begin miscompares++; $display("FAIL cpu_wr_ack_e2: got %b want 0", bus.cpu_ack); end
        vectors++; if (we_cycles - we0 !== 1) begin miscompares++; $display("FAIL cpu_wr_we_cycles: got %0d want 1", we_cycles - we0); end
        bus.cpu_we  = 1'b0;
        bus.cpu_req = 1'b1;
        tick();
        vectors++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL cpu_rd_en_we: got en=%b we=%b want 1 0", bus.ram_en, bus.ram_we); end
        tick();
        vectors++; if (bus.cpu_ack !== 1'b0) begin miscompares++; $display("FAIL cpu_rd_ack_e1: got %b want 0", bus.cpu_ack); end
        tick();
        vectors++; if (bus.cpu_ack !== 1'b1) begin miscompares++; $display("FAIL cpu_rd_ack_e2: got %b want 1", bus.cpu_ack); end
        vectors++; if (bus.cpu_rdata !== 8'hA5) begin miscompares++; $display("FAIL cpu_rd_data: got %h want a5", bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_contention();
        reset        = 1'b0;
        bus.vid_addr = 16'h0907;
        bus.cpu_addr = 16'h0903;
        bus.cpu_we   = 1'b0;
        bus.vid_req  = 1'b1;
        bus.cpu_req  = 1'b1;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            vectors++;
            if (bus.vid_ack !== ((c % 8) == 2)) begin
                miscompares++; $display("FAIL contend_vid_ack c%0d: got %b want %b", c, bus.vid_ack, (c % 8) == 2);
            end
            vectors++;
            if (bus.cpu_ack !== ((c % 8) == 6)) begin
                miscompares++; $display("FAIL contend_cpu_ack c%0d: got %b want %b", c, bus.cpu_ack, (c % 8) == 6);
            end
            if ((c % 8) == 2) begin
                vectors++;
                if (bus.vid_data !== 8'h07) begin miscompares++; $display("FAIL contend_vid_data c%0d: got %h want 07", c, bus.vid_data); end
            end
            if ((c % 8) == 6) begin
                vectors++;
                if (bus.cpu_rdata !== 8'h03) begin miscompares++; $display("FAIL contend_cpu_data c%0d: got %h want 03", c, bus.cpu_rdata); end
            end
        end
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_oob();
        bus.vid_addr = 16'h1234;
        bus.vid_req  = 1'b1;
        tick();
        vectors++; if (bus.ram_addr !== 16'h0934) begin miscompares++; $display("FAIL oob_ram_addr: got %h want 0934", bus.ram_addr); end
        vectors++; if (bus.vid_oob !== 1'b1) begin miscompares++; $display("FAIL oob_flag_set: got %b want 1", bus.vid_oob); end
        tick();
        tick();
        vectors++; if (bus.vid_ack !== 1'b1 || bus.vid_data !== 8'h34) begin miscompares++; $display("FAIL oob_ack_data: got ack=%b data=%h want 1 34", bus.vid_ack, bus.vid_data); end
        bus.vid_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (bus.vid_oob !== 1'b1) begin miscompares++; $display("FAIL oob_sticky c%0d: got %b want 1", c, bus.vid_oob); end
        end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL oob_idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_abort_and_reset();
        bus.cpu_addr  = 16'h09F1;
        bus.cpu_wdata = 8'h5A;
        bus.cpu_we    = 1'b1;
        bus.cpu_req   = 1'b1;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        vectors++; if (bus.cpu_ack !== 1'b1) begin miscompares++; $display("FAIL abort_cpu_ack: got %b want 1", bus.cpu_ack); end
        vectors++; if (mem[8'hF1] !== 8'h5A) begin miscompares++; $display("FAIL abort_write_done: got %h want 5a", mem[8'hF1]); end
        tick();
        tick();
        bus.vid_addr = 16'h0902;
        bus.vid_req  = 1'b1;
        tick();
        tick();
        vectors++; if (bus.busy !== 1'b1 || bus.vid_ack !== 1'b0) begin miscompares++; $display("FAIL rst_pre_capture: got busy=%b ack=%b want 1 0", bus.busy, bus.vid_ack); end
        reset = 1'b0;
        #1;
        vectors++; if (bus.busy !== 1'b0 || bus.ram_en !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy_en: got busy=%b en=%b want 0 0", bus.busy, bus.ram_en); end
        vectors++; if (bus.vid_oob !== 1'b0 || bus.ram_addr !== 16'h0900) begin miscompares++; $display("FAIL rst_async_oob_addr: got oob=%b addr=%h want 0 0900", bus.vid_oob, bus.ram_addr); end
        vectors++; if (bus.cpu_rdata !== 8'h00 || bus.ram_wdata !== 8'h00) begin miscompares++; $display("FAIL rst_async_data: got rdata=%h wdata=%h want 00 00", bus.cpu_rdata, bus.ram_wdata); end
        tick();
        vectors++; if (bus.vid_ack !== 1'b0 || bus.cpu_ack !== 1'b0) begin miscompares++; $display("FAIL rst_no_ack: got vid=%b cpu=%b want 0 0", bus.vid_ack, bus.cpu_ack); end
        vectors++; if (bus.vid_data !== 8'h00) begin miscompares++; $display("FAIL rst_vid_data: got %h want 00", bus.vid_data); end
        bus.vid_req = 1'b0;
        reset = 1'b1;
        tick();
        vectors++; if (bus.busy !== 1'b0 || bus.vid_ack !== 1'b0) begin miscompares++; $display("FAIL rst_release_idle: got busy=%b ack=%b want 0 0", bus.busy, bus.vid_ack); end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        we_cycles     = 0;
        we_without_en = 0;
        both_acks     = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        bus.ram_rdata = 8'h00;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = 16'h0900;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0900;
        bus.cpu_wdata = 8'h00;
        reset         = 1'b0;

        test_reset();
        test_video_read();
        test_cpu_write_read();
        test_contention();
        test_oob();
        test_abort_and_reset();

        vectors++; if (both_acks !== 0) begin miscompares++; $display("FAIL both_acks_cycles: got %0d want 0", both_acks); end
        vectors++; if (we_without_en !== 0) begin miscompares++; $display("FAIL we_without_en_cycles: got %0d want 0", we_without_en); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
